// File: rtl/conv_sequencer_param_if.sv
// Bundle of the AXI control words, the MAC-array strobes and the FIFO/BRAM status
// lines exchanged between the register file, the sequencer and the MAC array.
interface conv_sequencer_param_if #(
    parameter int MAC_NUM              = 256,
    parameter int CH_WIDTH             = 12,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
);
    logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_0;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_1;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_2;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_3;
    logic                            weight_from_bram_valid;
    logic                            ifmaps_fifo_empty;
    logic [1:0]                      operation;
    logic [4:0]                      kernel_size;
    logic [CH_WIDTH-1:0]             input_channel_size;
    logic                            address_reset;
    logic                            bram_row_inc;
    logic                            load_weight_preload;
    logic                            load_weight;
    logic                            load_ifmaps;
    logic [MAC_NUM-1:0]              MAC_enable;

    // Register file / array side: issues control words, reports FIFO and BRAM status
    modport master (
        output axi_control_0, axi_control_1, axi_control_2,
        output weight_from_bram_valid, ifmaps_fifo_empty,
        input  axi_control_3, operation, kernel_size, input_channel_size,
        input  address_reset, bram_row_inc, load_weight_preload, load_weight,
        input  load_ifmaps, MAC_enable
    );

    // Sequencer side
    modport slave (
        input  axi_control_0, axi_control_1, axi_control_2,
        input  weight_from_bram_valid, ifmaps_fifo_empty,
        output axi_control_3, operation, kernel_size, input_channel_size,
        output address_reset, bram_row_inc, load_weight_preload, load_weight,
        output load_ifmaps, MAC_enable
    );
endinterface

// File: rtl/conv_sequencer_param.sv
// Convolution sequencer for the MAC array. A rising COMPUTE opcode latches a job
// (kernel K, channel/filter count N, ofmap side D). The ifmap FSM loads K rows for
// the first pixel of each ofmap row and one row per horizontal step; for every pixel
// the weight FSM preloads K weight rows per filter and transfers each filter to the
// MAC array. Status (busy/done/cfg_err/pixel count) is returned on axi_control_3.
module conv_sequencer_param #(
    parameter int MAC_NUM              = 256,
    parameter int KMAX                 = 5,
    parameter int CH_WIDTH             = 12,
    parameter int DIM_WIDTH            = 9,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int INST_COMPUTE         = 87
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_sequencer_param_if.slave bus
);

    // Ifmap / raster FSM encodings
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_STEP    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // Weight preload FSM encodings
    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_RST_ADDR = 2'd1;
    localparam logic [1:0] W_PRE      = 2'd2;
    localparam logic [1:0] W_LOAD     = 2'd3;

    localparam logic [7:0] OPCODE_COMPUTE = 8'(INST_COMPUTE);

    // Decoded control-word fields
    logic [7:0]           opcode_in;
    logic [CH_WIDTH-1:0]  channel_in;
    logic [1:0]           operation_in;
    logic [DIM_WIDTH-1:0] dim_in;
    logic [4:0]           kernel_in;

    assign opcode_in    = bus.axi_control_0[7:0];
    assign channel_in   = bus.axi_control_0[8 +: CH_WIDTH];
    assign operation_in = bus.axi_control_1[1:0];
    assign dim_in       = bus.axi_control_1[2 +: DIM_WIDTH];
    assign kernel_in    = bus.axi_control_2[4:0];

    // Upper control-word bits carry nothing for this block
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{bus.axi_control_0[C_S_AXIS_TDATA_WIDTH-1:8+CH_WIDTH],
                                bus.axi_control_1[C_S_AXIS_TDATA_WIDTH-1:2+DIM_WIDTH],
                                bus.axi_control_2[C_S_AXIS_TDATA_WIDTH-1:5]};

    // State
    logic [2:0]           ifmap_state_q, ifmap_state_d;
    logic [4:0]           row_q, row_d;
    logic [DIM_WIDTH-1:0] x_q, x_d;
    logic [DIM_WIDTH-1:0] y_q, y_d;
    logic [1:0]           weight_state_q, weight_state_d;
    logic [4:0]           wrow_q, wrow_d;
    logic [CH_WIDTH-1:0]  filter_q, filter_d;
    logic [1:0]           operation_q, operation_d;
    logic [4:0]           kernel_q, kernel_d;
    logic [CH_WIDTH-1:0]  channel_q, channel_d;
    logic [DIM_WIDTH-1:0] dim_q, dim_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [15:0]          pixel_q, pixel_d;
    logic                 opcode_prev_q, opcode_prev_d;
    logic [MAC_NUM-1:0]   mac_enable_q, mac_enable_d;

    // Combinational strobes
    logic opcode_hit;
    logic start_edge;
    logic cfg_bad;
    logic filters_done;
    logic weight_start;
    logic load_ifmaps_c;
    logic address_reset_c;
    logic bram_row_inc_c;
    logic preload_c;
    logic load_weight_c;

    // Start is the first cycle the COMPUTE opcode appears; holding it does nothing more
    assign opcode_hit    = (opcode_in == OPCODE_COMPUTE);
    assign opcode_prev_d = opcode_hit;
    assign start_edge    = opcode_hit && !opcode_prev_q;

    // A job is rejected when any dimension is empty or exceeds the array
    assign cfg_bad = (kernel_in == 5'd0) || (int'(kernel_in) > KMAX) ||
                     (channel_in == '0) || (int'(channel_in) > MAC_NUM) ||
                     (dim_in == '0);

    // Last filter of the current pixel is being transferred
    assign filters_done = (weight_state_q == W_LOAD) && (filter_q == channel_q - 1'b1);

    // Ifmap / raster sequencing, job latch and status bookkeeping
    always_comb begin
        ifmap_state_d = ifmap_state_q;
        row_d         = row_q;
        x_d           = x_q;
        y_d           = y_q;
        operation_d   = operation_q;
        kernel_d      = kernel_q;
        channel_d     = channel_q;
        dim_d         = dim_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cfg_err_d     = cfg_err_q;
        pixel_d       = pixel_q;
        load_ifmaps_c = 1'b0;
        weight_start  = 1'b0;

        case (ifmap_state_q)
            S_IDLE: begin
                if (start_edge) begin
                    done_d = 1'b0;
                    if (cfg_bad) begin
                        // Rejected jobs leave the previous configuration in place
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d     = 1'b0;
                        busy_d        = 1'b1;
                        operation_d   = operation_in;
                        kernel_d      = kernel_in;
                        channel_d     = channel_in;
                        dim_d         = dim_in;
                        pixel_d       = '0;
                        row_d         = '0;
                        x_d           = '0;
                        y_d           = '0;
                        ifmap_state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (!bus.ifmaps_fifo_empty) begin
                    load_ifmaps_c = 1'b1;
                    if (row_q == kernel_q - 1'b1) begin
                        row_d         = '0;
                        weight_start  = 1'b1;
                        ifmap_state_d = S_COMPUTE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end

            S_STEP: begin
                if (!bus.ifmaps_fifo_empty) begin
                    load_ifmaps_c = 1'b1;
                    weight_start  = 1'b1;
                    ifmap_state_d = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
                if (filters_done) begin
                    if (pixel_q != 16'hFFFF) begin
                        pixel_d = pixel_q + 16'd1;
                    end
                    if (x_q == dim_q - 1'b1) begin
                        x_d = '0;
                        if (y_q == dim_q - 1'b1) begin
                            ifmap_state_d = S_FINISH;
                        end else begin
                            y_d           = y_q + 1'b1;
                            row_d         = '0;
                            ifmap_state_d = S_FILL;
                        end
                    end else begin
                        x_d           = x_q + 1'b1;
                        ifmap_state_d = S_STEP;
                    end
                end
            end

            S_FINISH: begin
                busy_d        = 1'b0;
                done_d        = 1'b1;
                ifmap_state_d = S_IDLE;
            end

            default: begin
                busy_d        = 1'b0;
                ifmap_state_d = S_IDLE;
            end
        endcase
    end

    // Per-pixel weight walk: address reset, K preload rows per filter, N filter transfers
    always_comb begin
        weight_state_d  = weight_state_q;
        wrow_d          = wrow_q;
        filter_d        = filter_q;
        address_reset_c = 1'b0;
        bram_row_inc_c  = 1'b0;
        preload_c       = 1'b0;
        load_weight_c   = 1'b0;

        case (weight_state_q)
            W_IDLE: begin
                if (weight_start) begin
                    filter_d       = '0;
                    weight_state_d = W_RST_ADDR;
                end
            end

            W_RST_ADDR: begin
                address_reset_c = 1'b1;
                wrow_d          = '0;
                weight_state_d  = W_PRE;
            end

            W_PRE: begin
                // An invalid BRAM row is a stall: no capture, no address advance
                preload_c = bus.weight_from_bram_valid;
                if (bus.weight_from_bram_valid) begin
                    if (wrow_q == kernel_q - 1'b1) begin
                        wrow_d         = '0;
                        weight_state_d = W_LOAD;
                    end else begin
                        bram_row_inc_c = 1'b1;
                        wrow_d         = wrow_q + 1'b1;
                    end
                end
            end

            W_LOAD: begin
                load_weight_c = 1'b1;
                if (filter_q == channel_q - 1'b1) begin
                    filter_d       = '0;
                    weight_state_d = W_IDLE;
                end else begin
                    filter_d       = filter_q + 1'b1;
                    wrow_d         = '0;
                    weight_state_d = W_PRE;
                end
            end

            default: begin
                weight_state_d = W_IDLE;
            end
        endcase
    end

    // MAC lane enables follow the next-cycle busy flag so they line up with status busy
    for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_mac_en
        assign mac_enable_d[gi] = busy_d && (gi < int'(channel_d));
    end

    // State register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifmap_state_q  <= S_IDLE;
            row_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            weight_state_q <= W_IDLE;
            wrow_q         <= '0;
            filter_q       <= '0;
            operation_q    <= '0;
            kernel_q       <= '0;
            channel_q      <= '0;
            dim_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            pixel_q        <= '0;
            opcode_prev_q  <= 1'b0;
            mac_enable_q   <= '0;
        end else begin
            ifmap_state_q  <= ifmap_state_d;
            row_q          <= row_d;
            x_q            <= x_d;
            y_q            <= y_d;
            weight_state_q <= weight_state_d;
            wrow_q         <= wrow_d;
            filter_q       <= filter_d;
            operation_q    <= operation_d;
            kernel_q       <= kernel_d;
            channel_q      <= channel_d;
            dim_q          <= dim_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            pixel_q        <= pixel_d;
            opcode_prev_q  <= opcode_prev_d;
            mac_enable_q   <= mac_enable_d;
        end
    end

    // Status word and outputs
    logic [31:0] status_word;
    assign status_word = {pixel_q, 13'd0, cfg_err_q, done_q, busy_q};

    assign bus.axi_control_3       = C_S_AXIS_TDATA_WIDTH'(status_word);
    assign bus.operation           = operation_q;
    assign bus.kernel_size         = kernel_q;
    assign bus.input_channel_size  = channel_q;
    assign bus.address_reset       = address_reset_c;
    assign bus.bram_row_inc        = bram_row_inc_c;
    assign bus.load_weight_preload = preload_c;
    assign bus.load_weight         = load_weight_c;
    assign bus.load_ifmaps         = load_ifmaps_c;
    assign bus.MAC_enable          = mac_enable_q;

endmodule

// File: tb/tb_conv_sequencer_param.sv
// Bench for conv_sequencer_param: jobs with random FIFO/BRAM back-pressure, pulse
// totals compared against closed-form counts derived from K, N and D.
module tb_conv_sequencer_param;
    localparam int MAC_NUM   = 256;
    localparam int KMAX      = 5;
    localparam int CH_WIDTH  = 12;
    localparam int DIM_WIDTH = 9;
    localparam int TW        = 32;
    localparam int INST      = 87;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_sequencer_param_if #(.MAC_NUM(MAC_NUM), .CH_WIDTH(CH_WIDTH),
                              .C_S_AXIS_TDATA_WIDTH(TW)) bus ();

    conv_sequencer_param #(
        .MAC_NUM(MAC_NUM), .KMAX(KMAX), .CH_WIDTH(CH_WIDTH), .DIM_WIDTH(DIM_WIDTH),
        .C_S_AXIS_TDATA_WIDTH(TW), .INST_COMPUTE(INST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cnt_ifm, cnt_lw, cnt_pre, cnt_inc, cnt_ar;

    // One clock: sample strobes mid-cycle, then return just after the next edge
    task automatic cycle();
        @(negedge clk);
        cnt_ifm += int'(bus.load_ifmaps);
        cnt_lw  += int'(bus.load_weight);
        cnt_pre += int'(bus.load_weight_preload);
        cnt_inc += int'(bus.bram_row_inc);
        cnt_ar  += int'(bus.address_reset);
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k, input int n, input int d, input int op, input bit hold);
        logic [31:0] kv, nv, dv, ov;
        kv = k; nv = n; dv = d; ov = op;
        bus.axi_control_0 = {12'd0, nv[11:0], 8'(INST)};
        bus.axi_control_1 = {21'd0, dv[8:0], ov[1:0]};
        bus.axi_control_2 = {27'd0, kv[4:0]};
        cnt_ifm = 0; cnt_lw = 0; cnt_pre = 0; cnt_inc = 0; cnt_ar = 0;
        cycle();
        if (!hold) bus.axi_control_0 = 32'd0;
    endtask

    task automatic run_to_done(input string name, input int bound, input int empty_pct, input int stall_pct);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            bus.ifmaps_fifo_empty      = (int'($urandom_range(99)) < empty_pct);
            bus.weight_from_bram_valid = (int'($urandom_range(99)) >= stall_pct);
            cycle();
            if (bus.axi_control_3[1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.ifmaps_fifo_empty      = 1'b0;
        bus.weight_from_bram_valid = 1'b1;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s done_timeout: done not seen within %0d cycles, required done=1", name, bound);
        end
    endtask

    // Full job with closed-form expectations on every strobe total
    task automatic test_job(input string name, input int k, input int n, input int d,
                            input int empty_pct, input int stall_pct, input bit hold);
        logic [MAC_NUM-1:0] exp_mask;
        logic [31:0] exp_status, nv, kv, ov;
        int op, bound;
        exp_mask = '0;
        for (int i = 0; i < n; i++) exp_mask[i] = 1'b1;
        op = int'($urandom_range(3));
        nv = n; kv = k; ov = op;
        start_job(k, n, d, op, hold);

        vectors++;
        if (bus.axi_control_3[0] !== 1'b1 || bus.MAC_enable !== exp_mask) begin
            miscompares++;
            $display("FAIL %s start: busy=%0b enabled_lanes=%0d, required busy=1 enabled_lanes=%0d",
                     name, bus.axi_control_3[0], $countones(bus.MAC_enable), n);
        end
        vectors++;
        if ({bus.operation, bus.kernel_size, bus.input_channel_size} !== {ov[1:0], kv[4:0], nv[11:0]}) begin
            miscompares++;
            $display("FAIL %s config: op=%0d k=%0d n=%0d, required op=%0d k=%0d n=%0d",
                     name, bus.operation, bus.kernel_size, bus.input_channel_size, op, k, n);
        end

        // Live control writes during a job must not disturb it
        bus.axi_control_1 = $urandom();
        bus.axi_control_2 = $urandom();
        if (!hold) bus.axi_control_0 = {12'd0, 12'($urandom()), 8'd0};

        bound = d * d * n * (k + 3) * 4 + d * (k + d) * 4 + 200;
        run_to_done(name, bound, empty_pct, stall_pct);

        exp_status = {16'(d * d), 16'h0002};
        vectors++;
        if (bus.axi_control_3 !== exp_status) begin
            miscompares++;
            $display("FAIL %s status: got %h, required %h", name, bus.axi_control_3, exp_status);
        end
        vectors++;
        if (cnt_ifm !== d * (k + d - 1)) begin
            miscompares++;
            $display("FAIL %s load_ifmaps: got %0d, required %0d", name, cnt_ifm, d * (k + d - 1));
        end
        vectors++;
        if (cnt_lw !== d * d * n) begin
            miscompares++;
            $display("FAIL %s load_weight: got %0d, required %0d", name, cnt_lw, d * d * n);
        end
        vectors++;
        if (cnt_pre !== d * d * n * k || cnt_inc !== d * d * n * (k - 1)) begin
            miscompares++;
            $display("FAIL %s preload/row_inc: got %0d/%0d, required %0d/%0d",
                     name, cnt_pre, cnt_inc, d * d * n * k, d * d * n * (k - 1));
        end
        vectors++;
        if (cnt_ar !== d * d) begin
            miscompares++;
            $display("FAIL %s address_reset: got %0d, required %0d", name, cnt_ar, d * d);
        end
        vectors++;
        if (bus.MAC_enable !== '0 || bus.kernel_size !== kv[4:0] || bus.input_channel_size !== nv[11:0]) begin
            miscompares++;
            $display("FAIL %s after_done: enabled_lanes=%0d k=%0d n=%0d, required 0/%0d/%0d",
                     name, $countones(bus.MAC_enable), bus.kernel_size, bus.input_channel_size, k, n);
        end
        $display("job %s K=%0d N=%0d D=%0d ifm=%0d lw=%0d pre=%0d inc=%0d ar=%0d status=%h",
                 name, k, n, d, cnt_ifm, cnt_lw, cnt_pre, cnt_inc, cnt_ar, bus.axi_control_3);
        bus.axi_control_1 = 32'd0;
        bus.axi_control_2 = 32'd0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.axi_control_3 !== 32'd0 || bus.MAC_enable !== '0 ||
            {bus.address_reset, bus.bram_row_inc, bus.load_weight_preload, bus.load_weight, bus.load_ifmaps} !== 5'd0 ||
            {bus.operation, bus.kernel_size, bus.input_channel_size} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: status=%h lanes=%0d k=%0d n=%0d, required all zero",
                     bus.axi_control_3, $countones(bus.MAC_enable), bus.kernel_size, bus.input_channel_size);
        end
        $display("reset status=%h", bus.axi_control_3);
    endtask

    // Weight BRAM stalls for 10 cycles with the preload row counter at 2
    task automatic test_weight_stall();
        int pre0, inc0, lw0;
        bit reached;
        start_job(5, 1, 1, 0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            cycle();
            reached = (cnt_pre == 2);
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL stall_reach: preload count %0d, required 2", cnt_pre);
        end
        bus.weight_from_bram_valid = 1'b0;
        pre0 = cnt_pre; inc0 = cnt_inc; lw0 = cnt_lw;
        repeat (10) cycle();
        vectors++;
        if (cnt_pre !== pre0 || cnt_inc !== inc0 || cnt_lw !== lw0) begin
            miscompares++;
            $display("FAIL stall_quiet: pre/inc/lw moved %0d/%0d/%0d -> %0d/%0d/%0d, required no change",
                     pre0, inc0, lw0, cnt_pre, cnt_inc, cnt_lw);
        end
        bus.weight_from_bram_valid = 1'b1;
        run_to_done("weight_stall", 100, 0, 0);
        vectors++;
        if (cnt_pre !== 5 || cnt_inc !== 4 || cnt_lw !== 1) begin
            miscompares++;
            $display("FAIL stall_resume: pre/inc/lw got %0d/%0d/%0d, required 5/4/1", cnt_pre, cnt_inc, cnt_lw);
        end
        $display("weight_stall pre=%0d inc=%0d lw=%0d", cnt_pre, cnt_inc, cnt_lw);
    endtask

    // Ifmap FIFO empty for 7 cycles while FILL waits on row 1
    task automatic test_fifo_stall();
        int k;
        bit reached;
        k = int'($urandom_range(KMAX, 2));
        start_job(k, 1, 1, 0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle();
            reached = (cnt_ifm == 1);
        end
        bus.ifmaps_fifo_empty = 1'b1;
        repeat (7) cycle();
        vectors++;
        if (!reached || cnt_ifm !== 1 || cnt_lw !== 0) begin
            miscompares++;
            $display("FAIL fifo_hold: ifm=%0d lw=%0d, required ifm=1 lw=0", cnt_ifm, cnt_lw);
        end
        bus.ifmaps_fifo_empty = 1'b0;
        run_to_done("fifo_stall", 200, 0, 0);
        vectors++;
        if (cnt_ifm !== k) begin
            miscompares++;
            $display("FAIL fifo_total: ifm=%0d, required %0d", cnt_ifm, k);
        end
        $display("fifo_stall K=%0d ifm=%0d", k, cnt_ifm);
    endtask

    // Rejected configurations, then a good job clears the error
    task automatic test_cfg_err();
        int bad_k[5] = '{6, 0, 3, 3, 1};
        int bad_n[5] = '{1, 1, 0, 1, 257};
        int bad_d[5] = '{1, 1, 1, 0, 1};
        for (int c = 0; c < 5; c++) begin
            start_job(bad_k[c], bad_n[c], bad_d[c], 0, 1'b0);
            repeat (3) cycle();
            vectors++;
            if (bus.axi_control_3[2:0] !== 3'b100 || cnt_ifm !== 0 || bus.MAC_enable !== '0) begin
                miscompares++;
                $display("FAIL cfg_err_%0d: status[2:0]=%b ifm=%0d, required 100 and 0",
                         c, bus.axi_control_3[2:0], cnt_ifm);
            end
            $display("cfg_err K=%0d N=%0d D=%0d status=%h", bad_k[c], bad_n[c], bad_d[c], bus.axi_control_3);
        end
        test_job("recover", 2, 2, 2, 0, 0, 1'b0);
    endtask

    // Opcode held high across done must not start a second job
    task automatic test_held_opcode();
        int ifm0;
        test_job("held", 2, 3, 2, 20, 20, 1'b1);
        ifm0 = cnt_ifm;
        repeat (20) cycle();
        vectors++;
        if (bus.axi_control_3[1:0] !== 2'b10 || cnt_ifm !== ifm0) begin
            miscompares++;
            $display("FAIL held_opcode: status[1:0]=%b ifm=%0d, required 10 and %0d",
                     bus.axi_control_3[1:0], cnt_ifm, ifm0);
        end
        bus.axi_control_0 = 32'd0;
        cycle();
    endtask

    // Reset asserted while filters are being loaded
    task automatic test_reset_mid();
        bit reached;
        start_job(3, 4, 2, 1, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle();
            reached = (cnt_lw >= 2);
        end
        rst_n = 1'b0;
        cycle();
        vectors++;
        if (!reached || bus.axi_control_3 !== 32'd0 || bus.MAC_enable !== '0 ||
            {bus.address_reset, bus.bram_row_inc, bus.load_weight_preload, bus.load_weight, bus.load_ifmaps} !== 5'd0 ||
            {bus.operation, bus.kernel_size, bus.input_channel_size} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid: reached=%0b status=%h lanes=%0d k=%0d, required all zero",
                     reached, bus.axi_control_3, $countones(bus.MAC_enable), bus.kernel_size);
        end
        rst_n = 1'b1;
        repeat (5) cycle();
        vectors++;
        if (bus.axi_control_3 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_no_done: status=%h, required 00000000", bus.axi_control_3);
        end
        $display("reset_mid status=%h", bus.axi_control_3);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 8; j++) begin
            test_job("random", int'($urandom_range(KMAX, 1)), int'($urandom_range(8, 1)),
                     int'($urandom_range(4, 1)), 30, 30, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.axi_control_0          = 32'd0;
        bus.axi_control_1          = 32'd0;
        bus.axi_control_2          = 32'd0;
        bus.ifmaps_fifo_empty      = 1'b0;
        bus.weight_from_bram_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        cycle();
        test_job("min", 1, 1, 1, 0, 0, 1'b0);
        test_job("k3n4d2", 3, 4, 2, 0, 0, 1'b0);
        test_weight_stall();
        test_fifo_stall();
        test_cfg_err();
        test_held_opcode();
        test_job("max_lanes", 1, MAC_NUM, 1, 10, 10, 1'b0);
        test_random_jobs();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
